// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates behind rename, takes out-of-order completions,
// retires up to two entries per cycle and returns freed physical registers as a one-hot mask.
// Optional statistics counters are built when ROB_STATS_EN is defined.
module reorder_buffer #(
  parameter int DEPTH     = 16,
  parameter int IDX_W     = 4,
  parameter int PREG_NONE = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_dr_a,
  input  logic [5:0]       alloc_dr_p,
  input  logic [6:0]       alloc_old_dr,
  output logic             alloc_ready,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             cmpl_valid,
  input  logic [IDX_W-1:0] cmpl_idx,
  output logic [63:0]      retire_from_ROB,
  output logic [1:0]       retire_cnt,
  output logic [5:0]       retire_dr_p0,
  output logic [5:0]       retire_dr_p1,
  output logic             rob_empty,
  output logic [IDX_W:0]   rob_count
`ifdef ROB_STATS_EN
  ,
  output logic [31:0]      stat_full_cycles,
  output logic [31:0]      stat_retired,
  output logic [31:0]      stat_alloc_stalls
`endif
);

  logic [IDX_W:0]            head_q, head_d, tail_q, tail_d, count;
  logic [DEPTH-1:0]          valid_q, valid_d, done_q, done_d;
  logic [DEPTH-1:0][4:0]     dr_a_q;
  logic [DEPTH-1:0][5:0]     dr_p_q;
  logic [DEPTH-1:0][6:0]     old_dr_q;
  logic [63:0]               mask_q, mask_d;
  logic [1:0]                rcnt_q, rcnt_d;
  logic [5:0]                rdp0_q, rdp0_d, rdp1_q, rdp1_d;
  logic [IDX_W-1:0]          h0, h1;
  logic                      full, do_alloc, ret0, ret1, free0, free1;

  assign count       = tail_q - head_q;
  assign full        = (count == (IDX_W+1)'(DEPTH));
  assign alloc_ready = !full;
  assign alloc_idx   = tail_q[IDX_W-1:0];
  assign rob_count   = count;
  assign rob_empty   = (count == '0);
  assign do_alloc    = alloc_valid && alloc_ready;

  assign h0   = head_q[IDX_W-1:0];
  assign h1   = h0 + 1'b1;
  assign ret0 = valid_q[h0] && done_q[h0];
  assign ret1 = ret0 && valid_q[h1] && done_q[h1];

  // An old_dr at or above 64 (PREG_NONE included) has no free-list bit.
  assign free0 = !old_dr_q[h0][6] && ({25'd0, old_dr_q[h0]} != PREG_NONE);
  assign free1 = !old_dr_q[h1][6] && ({25'd0, old_dr_q[h1]} != PREG_NONE);

  // The architectural destination is held for recovery/debug visibility only.
  logic unused_dr_a;
  assign unused_dr_a = ^dr_a_q;

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path infers a latch.
    valid_d = valid_q;
    done_d  = done_q;
    mask_d  = '0;
    rdp0_d  = '0;
    rdp1_d  = '0;
    rcnt_d  = {ret1, ret0 ^ ret1};

    if (cmpl_valid && valid_q[cmpl_idx]) done_d[cmpl_idx] = 1'b1;
    if (ret0) begin
      valid_d[h0] = 1'b0;
      done_d[h0]  = 1'b0;
      rdp0_d      = dr_p_q[h0];
      if (free0) mask_d[old_dr_q[h0][5:0]] = 1'b1;
    end
    if (ret1) begin
      valid_d[h1] = 1'b0;
      done_d[h1]  = 1'b0;
      rdp1_d      = dr_p_q[h1];
      if (free1) mask_d[old_dr_q[h1][5:0]] = 1'b1;
    end
    // Allocation is applied last so it overrides a same-index completion.
    if (do_alloc) begin
      valid_d[alloc_idx] = 1'b1;
      done_d[alloc_idx]  = 1'b0;
    end

    head_d = head_q + (IDX_W+1)'(rcnt_d);
    tail_d = tail_q + (IDX_W+1)'(do_alloc);
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= '0;
      done_q  <= '0;
      mask_q  <= '0;
      rcnt_q  <= '0;
      rdp0_q  <= '0;
      rdp1_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      rcnt_q  <= rcnt_d;
      rdp0_q  <= rdp0_d;
      rdp1_q  <= rdp1_d;
    end
  end

  // NOTE: payload storage is not reset; the reset valid bits make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (do_alloc) begin
      dr_a_q[alloc_idx]   <= alloc_dr_a;
      dr_p_q[alloc_idx]   <= alloc_dr_p;
      old_dr_q[alloc_idx] <= alloc_old_dr;
    end
  end

  assign retire_from_ROB = mask_q;
  assign retire_cnt      = rcnt_q;
  assign retire_dr_p0    = rdp0_q;
  assign retire_dr_p1    = rdp1_q;

`ifdef ROB_STATS_EN
  logic [31:0] full_cyc_q, retired_q, stalls_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_cyc_q <= '0;
      retired_q  <= '0;
      stalls_q   <= '0;
    end else begin
      if (full && full_cyc_q != '1) full_cyc_q <= full_cyc_q + 32'd1;
      if (alloc_valid && !alloc_ready && stalls_q != '1) stalls_q <= stalls_q + 32'd1;
      if (retired_q > (32'hFFFF_FFFF - {30'd0, rcnt_d})) retired_q <= '1;
      else retired_q <= retired_q + {30'd0, rcnt_d};
    end
  end

  assign stat_full_cycles  = full_cyc_q;
  assign stat_retired      = retired_q;
  assign stat_alloc_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: allocation, paired/single retirement,
// full-buffer stall, double wrap-around and mid-flight reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_dr_a = '0;
  logic [5:0]  alloc_dr_p = '0;
  logic [6:0]  alloc_old_dr = '0;
  logic        alloc_ready;
  logic [3:0]  alloc_idx;
  logic        cmpl_valid = 1'b0;
  logic [3:0]  cmpl_idx = '0;
  logic [63:0] retire_from_ROB;
  logic [1:0]  retire_cnt;
  logic [5:0]  retire_dr_p0, retire_dr_p1;
  logic        rob_empty;
  logic [4:0]  rob_count;
`ifdef ROB_STATS_EN
  logic [31:0] stat_full_cycles, stat_retired, stat_alloc_stalls;
`endif

  int errors = 0;
  int checks = 0;
  int tail_m = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_dr_a(alloc_dr_a), .alloc_dr_p(alloc_dr_p),
    .alloc_old_dr(alloc_old_dr), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .retire_from_ROB(retire_from_ROB), .retire_cnt(retire_cnt),
    .retire_dr_p0(retire_dr_p0), .retire_dr_p1(retire_dr_p1),
    .rob_empty(rob_empty), .rob_count(rob_count)
`ifdef ROB_STATS_EN
    , .stat_full_cycles(stat_full_cycles), .stat_retired(stat_retired),
    .stat_alloc_stalls(stat_alloc_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", alloc_ready); end
    checks++; if (alloc_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", alloc_idx); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", rob_empty); end
    checks++; if (rob_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", rob_count); end
    checks++; if (retire_cnt !== 2'd0 || retire_from_ROB !== 64'd0) begin
      errors++; $display("FAIL reset_retire got cnt=%0d mask=%h exp 0/0", retire_cnt, retire_from_ROB); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_alloc();
    logic [5:0] dp [3];
    logic [6:0] od [3];
    dp = '{6'd40, 6'd41, 6'd42};
    od = '{7'd5, 7'd6, 7'd64};
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1'b1; alloc_dr_a = 5'(i + 1); alloc_dr_p = dp[i]; alloc_old_dr = od[i];
      checks++; if (alloc_idx !== 4'(i)) begin errors++; $display("FAIL alloc_idx got=%0d exp=%0d", alloc_idx, i); end
      step();
      tail_m++;
    end
    alloc_valid = 1'b0;
    checks++; if (rob_count !== 5'd3) begin errors++; $display("FAIL alloc_count got=%0d exp=3", rob_count); end
    checks++; if (retire_from_ROB !== 64'd0) begin errors++; $display("FAIL alloc_mask got=%h exp=0", retire_from_ROB); end
  endtask

  task automatic test_retire_pair();
    cmpl_valid = 1'b1; cmpl_idx = 4'd1;
    step();
    cmpl_idx = 4'd0;
    step();
    cmpl_valid = 1'b0;
    checks++; if (retire_cnt !== 2'd0) begin errors++; $display("FAIL pair_no_ooo got=%0d exp=0", retire_cnt); end
    step();
    checks++; if (retire_cnt !== 2'd2) begin errors++; $display("FAIL pair_cnt got=%0d exp=2", retire_cnt); end
    checks++; if (retire_from_ROB !== 64'h60) begin errors++; $display("FAIL pair_mask got=%h exp=60", retire_from_ROB); end
    checks++; if (retire_dr_p0 !== 6'd40 || retire_dr_p1 !== 6'd41) begin
      errors++; $display("FAIL pair_drp got=%0d,%0d exp=40,41", retire_dr_p0, retire_dr_p1); end
    checks++; if (rob_count !== 5'd1) begin errors++; $display("FAIL pair_pending got=%0d exp=1", rob_count); end
    step();
    checks++; if (retire_cnt !== 2'd0 || retire_from_ROB !== 64'd0) begin
      errors++; $display("FAIL pair_pulse got cnt=%0d mask=%h exp 0/0", retire_cnt, retire_from_ROB); end
  endtask

  task automatic test_retire_single();
    cmpl_valid = 1'b1; cmpl_idx = 4'd2;
    step();
    cmpl_valid = 1'b0;
    step();
    checks++; if (retire_cnt !== 2'd1) begin errors++; $display("FAIL single_cnt got=%0d exp=1", retire_cnt); end
    checks++; if (retire_dr_p0 !== 6'd42) begin errors++; $display("FAIL single_drp got=%0d exp=42", retire_dr_p0); end
    checks++; if (retire_from_ROB !== 64'd0) begin errors++; $display("FAIL single_mask got=%h exp=0", retire_from_ROB); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL single_empty got=%b exp=1", rob_empty); end
  endtask

  task automatic test_full();
    int head_idx;
    int total;
    head_idx = tail_m % 16;
    for (int k = 0; k < 16; k++) begin
      alloc_valid = 1'b1; alloc_dr_a = 5'(k); alloc_dr_p = 6'(16 + k); alloc_old_dr = 7'(k);
      step();
      tail_m++;
    end
    alloc_valid = 1'b0;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", alloc_ready); end
    checks++; if (rob_count !== 5'd16) begin errors++; $display("FAIL full_count got=%0d exp=16", rob_count); end
    cmpl_valid = 1'b1; cmpl_idx = 4'(head_idx);
    step();
    cmpl_valid = 1'b0;
    alloc_valid = 1'b1; alloc_dr_p = 6'd50; alloc_old_dr = 7'd20;
    checks++; if (alloc_ready !== 1'b0) begin errors++; $display("FAIL full_stall got=%b exp=0", alloc_ready); end
    step();
    checks++; if (retire_cnt !== 2'd1 || retire_dr_p0 !== 6'd16 || retire_from_ROB !== 64'd1) begin
      errors++; $display("FAIL full_retire got cnt=%0d drp=%0d mask=%h exp 1/16/1", retire_cnt, retire_dr_p0, retire_from_ROB); end
    checks++; if (rob_count !== 5'd15) begin errors++; $display("FAIL full_reject got=%0d exp=15", rob_count); end
    checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 4'(head_idx)) begin
      errors++; $display("FAIL full_reuse got ready=%b idx=%0d exp 1/%0d", alloc_ready, alloc_idx, head_idx); end
    step();
    tail_m++;
    alloc_valid = 1'b0;
    checks++; if (rob_count !== 5'd16) begin errors++; $display("FAIL full_accept got=%0d exp=16", rob_count); end
    total = 0;
    for (int c = 0; c < 40; c++) begin
      cmpl_valid = (c < 16); cmpl_idx = 4'(15 - (c % 16));
      step();
      total += int'(retire_cnt);
    end
    cmpl_valid = 1'b0;
    checks++; if (total != 16) begin errors++; $display("FAIL full_drain got=%0d exp=16", total); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL full_drain_empty got=%b exp=1", rob_empty); end
  endtask

  task automatic test_wrap();
    int base, nalloc, next_ret, j;
    logic [63:0] m;
    logic [5:0] act;
    logic [6:0] od;
    base = tail_m;
    nalloc = 0;
    next_ret = 0;
    for (int c = 0; c < 120 && next_ret < 40; c++) begin
      alloc_valid = (nalloc < 40);
      if (alloc_valid) begin
        alloc_dr_a = 5'(nalloc); alloc_dr_p = 6'(nalloc);
        alloc_old_dr = (nalloc % 3 == 0) ? 7'd64 : 7'(nalloc + 20);
        checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 4'((base + nalloc) % 16)) begin
          errors++; $display("FAIL wrap_idx got ready=%b idx=%0d exp 1/%0d", alloc_ready, alloc_idx, (base + nalloc) % 16); end
      end
      cmpl_valid = (c >= 2 && c < 42);
      cmpl_idx = 4'((base + ((c - 2) ^ 1)) % 16);
      step();
      if (alloc_valid) begin nalloc++; tail_m++; end
      checks++; if (retire_cnt > 2'd2) begin errors++; $display("FAIL wrap_cnt got=%0d exp<=2", retire_cnt); end
      m = '0;
      for (int s = 0; s < int'(retire_cnt) && s < 2; s++) begin
        j = next_ret + s;
        act = (s == 0) ? retire_dr_p0 : retire_dr_p1;
        checks++; if (act !== 6'(j)) begin errors++; $display("FAIL wrap_order slot%0d got=%0d exp=%0d", s, act, j); end
        od = (j % 3 == 0) ? 7'd64 : 7'(j + 20);
        if (od < 7'd64) m[od[5:0]] = 1'b1;
      end
      next_ret += int'(retire_cnt);
      checks++; if (retire_from_ROB !== m) begin errors++; $display("FAIL wrap_mask got=%h exp=%h", retire_from_ROB, m); end
      checks++; if (rob_count > 5'd16) begin errors++; $display("FAIL wrap_bound got=%0d exp<=16", rob_count); end
    end
    alloc_valid = 1'b0;
    cmpl_valid = 1'b0;
    checks++; if (next_ret != 40) begin errors++; $display("FAIL wrap_total got=%0d exp=40", next_ret); end
    checks++; if (rob_empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", rob_empty); end
  endtask

  task automatic test_reset_inflight();
    int base;
    base = tail_m % 16;
    for (int k = 0; k < 5; k++) begin
      alloc_valid = 1'b1; alloc_dr_a = 5'(k); alloc_dr_p = 6'(50 + k); alloc_old_dr = 7'(k + 1);
      step();
      tail_m++;
    end
    alloc_valid = 1'b0;
    cmpl_valid = 1'b1;
    cmpl_idx = 4'((base + 1) % 16); step();
    cmpl_idx = 4'((base + 3) % 16); step();
    cmpl_idx = 4'(base);            step();
    cmpl_valid = 1'b0;
    step();
    checks++; if (retire_cnt !== 2'd2 || retire_from_ROB !== 64'h6) begin
      errors++; $display("FAIL rst_pre got cnt=%0d mask=%h exp 2/6", retire_cnt, retire_from_ROB); end
    #1 rst = 1'b1;
    #1;
    checks++; if (retire_cnt !== 2'd0 || retire_from_ROB !== 64'd0 || retire_dr_p0 !== 6'd0) begin
      errors++; $display("FAIL rst_async_out got cnt=%0d mask=%h drp0=%0d exp 0", retire_cnt, retire_from_ROB, retire_dr_p0); end
    checks++; if (rob_empty !== 1'b1 || rob_count !== 5'd0) begin
      errors++; $display("FAIL rst_async_empty got empty=%b count=%0d exp 1/0", rob_empty, rob_count); end
    checks++; if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
      errors++; $display("FAIL rst_async_alloc got ready=%b idx=%0d exp 1/0", alloc_ready, alloc_idx); end
    step();
    rst = 1'b0;
    tail_m = 0;
    cmpl_valid = 1'b1; cmpl_idx = 4'((base + 2) % 16);
    step();
    cmpl_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      checks++; if (retire_cnt !== 2'd0 || retire_from_ROB !== 64'd0 || rob_empty !== 1'b1) begin
        errors++; $display("FAIL rst_no_pulse got cnt=%0d mask=%h empty=%b exp 0/0/1", retire_cnt, retire_from_ROB, rob_empty); end
    end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_retire_pair();
    test_retire_single();
    test_full();
    test_wrap();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order reorder buffer directly downstream of the rename stage.
- Allocates one entry per dispatched instruction and records the architectural destination, the new physical destination and the previous physical mapping (old_dr).
- Accepts out-of-order completion notices from the functional units.
- Retires up to two entries per cycle in program order. On retirement it produces the 64-bit one-hot mask of physical registers that rename returns to its free pool.

Parameters:
- DEPTH, 16: number of ROB entries; must be a power of 2, minimum 4.
- IDX_W, 4: entry index width, equal to log2(DEPTH).
- PREG_NONE, 64: old_dr value meaning "no physical register to free" (stores and NOPs).

Ports:
- clk  in  1: clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- alloc_valid  in  1: rename is dispatching one instruction this cycle.
- alloc_dr_a  in  5: architectural destination register.
- alloc_dr_p  in  6: new physical destination register.
- alloc_old_dr  in  7: previous physical mapping of alloc_dr_a, or PREG_NONE.
- alloc_ready  out  1: ROB can accept an allocation this cycle (not full).
- alloc_idx  out  IDX_W: index assigned to the current allocation (tail pointer), combinational.
- cmpl_valid  in  1: a functional unit reports an instruction finished.
- cmpl_idx  in  IDX_W: ROB index of the finished instruction.
- retire_from_ROB  out  64: one-hot-per-bit mask of physical registers freed; registered, pulses for one cycle.
- retire_cnt  out  2: number of entries retired in the previous cycle (0..2); registered.
- retire_dr_p0, retire_dr_p1  out  6: physical destinations retired (slot 0 is older); valid when retire_cnt > slot number.
- rob_empty  out  1: no valid entries.
- rob_count  out  IDX_W+1: number of valid entries.

Behaviour:
- Storage:
  - Circular array of DEPTH entries. Each entry holds {valid, done, dr_a, dr_p, old_dr}.
  - head and tail pointers, each IDX_W+1 bits including a wrap bit.
  - rob_count = tail - head, modulo 2^(IDX_W+1).
  - full when rob_count == DEPTH; empty when rob_count == 0.
- Reset:
  - While rst is high, and immediately on its assertion, all valid/done bits clear, head = tail = 0, and all registered outputs are 0.
  - Resulting output values: alloc_ready = 1, alloc_idx = 0, rob_empty = 1, rob_count = 0.
  - Reset asserted mid-operation discards all in-flight entries. No retire mask is emitted for them.
- Allocation:
  - Accepted on a rising edge when alloc_valid && alloc_ready.
  - The entry at tail[IDX_W-1:0] is written with valid = 1, done = 0 and the supplied fields; tail then increments.
  - alloc_ready is computed from the start-of-cycle count. A retirement in the same cycle does not make room for an allocation in that cycle.
  - alloc_valid while full is ignored; nothing is written and no error is raised.
- Completion:
  - On cmpl_valid, the entry at cmpl_idx gets done = 1 if that entry is valid.
  - Completion to an invalid entry is ignored.
  - Completion and allocation to the same index in one cycle: allocation wins and done stays 0.
- Retirement (every cycle, using start-of-cycle state):
  - Slot 0 retires if entry[head] is valid and done.
  - Slot 1 retires only if slot 0 retires and entry[head+1] is valid and done. There is never out-of-order retirement.
  - Each retired entry is invalidated and head advances by retire_cnt.
  - A completion arriving in the same cycle as a head-entry check takes effect next cycle, so completion-to-retire latency is 1 cycle minimum.
- Retire outputs, registered and valid the cycle after the retiring edge:
  - retire_from_ROB bit old_dr is set for each retired entry with old_dr < 64. The mask is 0 in cycles with no retirement.
  - If two retired entries free the same bit (not legal upstream), the bit is simply set once.
  - old_dr >= 64 sets no bit.
- Wrap-around: index arithmetic is modulo DEPTH. When head+1 crosses DEPTH-1 it wraps to 0.
- Simultaneous alloc and retire in one cycle: rob_count(next) = rob_count + 1 - retire_cnt.

Optional Feature:
- Macro: ROB_STATS_EN.
- When defined, the block adds 32-bit output counters stat_full_cycles, stat_retired and stat_alloc_stalls:
  - stat_full_cycles: cycles with rob_count == DEPTH.
  - stat_retired: total entries retired.
  - stat_alloc_stalls: cycles with alloc_valid && !alloc_ready.
  - All three reset to 0 and saturate at 2^32-1.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset, then allocate 3 entries (dr_p = 40, 41, 42; old_dr = 5, 6, 64) → alloc_idx reads 0, 1, 2; rob_count = 3; retire_from_ROB = 0.
- Complete idx 1, then idx 0 → next cycle retire_cnt = 2 and retire_from_ROB = (1<<5)|(1<<6); idx 2 stays pending.
- Complete idx 2 only (old_dr = 64) → retire_cnt = 1, retire_dr_p0 = 42, retire_from_ROB = 0.
- Fill all 16 entries → alloc_ready = 0. Assert alloc_valid with a simultaneous retire → allocation rejected this cycle, accepted next cycle at the freed index.
- Run 40 alloc/complete/retire iterations so head and tail wrap twice → indices wrap 15→0, retire order matches allocation order, and rob_count never exceeds 16.
- Assert rst with 5 entries outstanding, some done → all outputs 0 immediately, rob_empty = 1, and no retire pulse after rst deasserts.
